// File: rtl/dcache_pkg.sv
// Shared types and default widths for the data-cache controller.
//
// Contents:
//   instr_type_t  - CPU request kind (READ / WRITE)
//   state_t       - controller FSM states (IDLE / WB / FILL / RESP)
//   *_DEF         - default parameter values for the controller
package dcache_pkg;

    localparam int NUM_LINES_DEF = 8;
    localparam int ADDR_W_DEF    = 16;
    localparam int WORD_W_DEF    = 16;
    localparam int BLOCK_W_DEF   = 32;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } instr_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Tag / valid / dirty / data storage for a direct-mapped cache.
//
// Ports:
//   clk, rst               clock, async active-high reset (clears valid/dirty)
//   rd_idx                 combinational read index
//   rd_tag/valid/dirty/data contents of line rd_idx
//   wr_idx                 write index (shared by all write enables)
//   wr_line_en, wr_line    data write
//   wr_tag_en, wr_tag      tag write
//   wr_valid_en, wr_valid  valid-bit write
//   wr_dirty_en, wr_dirty  dirty-bit write
module dcache_line_array #(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 11,
    parameter int BLOCK_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_line_en,
    input  logic [BLOCK_W-1:0] wr_line,
    input  logic               wr_tag_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_valid_en,
    input  logic               wr_valid,
    input  logic               wr_dirty_en,
    input  logic               wr_dirty
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_valid_en) valid_d[wr_idx] = wr_valid;
        if (wr_dirty_en) dirty_d[wr_idx] = wr_dirty;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // NOTE: tag/data storage is deliberately not reset; the cleared valid
    // bits make its contents irrelevant and keep it mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_line_en) data_q[wr_idx] <= wr_line;
        if (wr_tag_en)  tag_q[wr_idx]  <= wr_tag;
    end

    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_mem_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Accepts one CPU request at a time, writes back a dirty victim, fills the
// line from word-addressed block RAM, then answers with a one-cycle pulse.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   cpu_req_valid/ready             request handshake (ready only in IDLE)
//   cpu_req_type, cpu_addr, cpu_wdata  request contents, latched at accept
//   cpu_resp_valid, cpu_rdata, cpu_resp_err  one-cycle response
//   mem_addr, mem_wdata             block-aligned address / victim line
//   mem_store_req, mem_store_done   writeback handshake (level req)
//   mem_load_req, mem_load_done, mem_rdata  fill handshake (level req)
//   hit_cnt, miss_cnt               saturating counters, only when
//                                   CACHE_STATS_EN is defined
module dcache_mem_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int BLOCK_W   = BLOCK_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req_valid,
    output logic               cpu_req_ready,
    input  instr_type_t        cpu_req_type,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic               cpu_resp_valid,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_resp_err,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    output logic               mem_store_req,
    input  logic               mem_store_done,
    output logic               mem_load_req,
    input  logic               mem_load_done,
    input  logic [BLOCK_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    state_t            state_q,     state_d;
    logic [TAG_W-1:0]  req_tag_q,   req_tag_d;
    logic [IDX_W-1:0]  req_idx_q,   req_idx_d;
    logic              req_hw_q,    req_hw_d;
    instr_type_t       req_type_q,  req_type_d;
    logic [WORD_W-1:0] req_wdata_q, req_wdata_d;
    logic              err_q,       err_d;
    logic [WORD_W-1:0] rdata_q,     rdata_d;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [TAG_W-1:0]   arr_tag;
    logic               arr_valid;
    logic               arr_dirty;
    logic [BLOCK_W-1:0] arr_data;
    logic               hit;

    logic               wr_line_en;
    logic [BLOCK_W-1:0] wr_line;
    logic               wr_tag_en;
    logic               wr_valid_en;
    logic               wr_valid;
    logic               wr_dirty_en;
    logic               wr_dirty;

    function automatic logic [WORD_W-1:0] select_hw(input logic [BLOCK_W-1:0] line,
                                                    input logic sel);
        return sel ? line[BLOCK_W-1 -: WORD_W] : line[WORD_W-1:0];
    endfunction

    function automatic logic [BLOCK_W-1:0] merge_hw(input logic [BLOCK_W-1:0] line,
                                                    input logic [WORD_W-1:0] wd,
                                                    input logic sel);
        logic [BLOCK_W-1:0] res;
        res = line;
        if (sel) res[BLOCK_W-1 -: WORD_W] = wd;
        else     res[WORD_W-1:0]          = wd;
        return res;
    endfunction

    // The lookup must happen in the accept cycle, before the request is
    // latched, so IDLE indexes straight from the CPU address.
    assign lk_idx = (state_q == IDLE) ? cpu_addr[IDX_W+1:2]        : req_idx_q;
    assign lk_tag = (state_q == IDLE) ? cpu_addr[ADDR_W-1:IDX_W+2] : req_tag_q;
    assign hit    = arr_valid && (arr_tag == lk_tag);

    dcache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .BLOCK_W   (BLOCK_W)
    ) u_lines (
        .clk         (clk),
        .rst         (rst),
        .rd_idx      (lk_idx),
        .rd_tag      (arr_tag),
        .rd_valid    (arr_valid),
        .rd_dirty    (arr_dirty),
        .rd_data     (arr_data),
        .wr_idx      (lk_idx),
        .wr_line_en  (wr_line_en),
        .wr_line     (wr_line),
        .wr_tag_en   (wr_tag_en),
        .wr_tag      (req_tag_q),
        .wr_valid_en (wr_valid_en),
        .wr_valid    (wr_valid),
        .wr_dirty_en (wr_dirty_en),
        .wr_dirty    (wr_dirty)
    );

    always_comb begin
        state_d     = state_q;
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        req_hw_d    = req_hw_q;
        req_type_d  = req_type_q;
        req_wdata_d = req_wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        wr_line_en  = 1'b0;
        wr_line     = arr_data;
        wr_tag_en   = 1'b0;
        wr_valid_en = 1'b0;
        wr_valid    = 1'b0;
        wr_dirty_en = 1'b0;
        wr_dirty    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_valid) begin
                    req_tag_d   = cpu_addr[ADDR_W-1:IDX_W+2];
                    req_idx_d   = cpu_addr[IDX_W+1:2];
                    req_hw_d    = cpu_addr[1];
                    req_type_d  = cpu_req_type;
                    req_wdata_d = cpu_wdata;
                    err_d       = cpu_addr[0];
                    rdata_d     = '0;
                    if (cpu_addr[0]) begin
                        state_d = RESP;
                    end else if (hit) begin
                        if (cpu_req_type == READ) begin
                            rdata_d = select_hw(arr_data, cpu_addr[1]);
                        end else begin
                            wr_line_en  = 1'b1;
                            wr_line     = merge_hw(arr_data, cpu_wdata, cpu_addr[1]);
                            wr_dirty_en = 1'b1;
                            wr_dirty    = 1'b1;
                        end
                        state_d = RESP;
                    end else if (arr_valid && arr_dirty) begin
                        state_d = WB;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WB: begin
                if (mem_store_done) begin
                    wr_dirty_en = 1'b1;
                    wr_dirty    = 1'b0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (mem_load_done) begin
                    wr_line_en  = 1'b1;
                    wr_tag_en   = 1'b1;
                    wr_valid_en = 1'b1;
                    wr_valid    = 1'b1;
                    // Fill clears dirty; a store merged into the fill re-dirties it.
                    wr_dirty_en = 1'b1;
                    wr_dirty    = (req_type_q == WRITE);
                    if (req_type_q == WRITE) begin
                        wr_line = merge_hw(mem_rdata, req_wdata_q, req_hw_q);
                    end else begin
                        wr_line = mem_rdata;
                        rdata_d = select_hw(mem_rdata, req_hw_q);
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_hw_q    <= 1'b0;
            req_type_q  <= READ;
            req_wdata_q <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            req_hw_q    <= req_hw_d;
            req_type_q  <= req_type_d;
            req_wdata_q <= req_wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign cpu_req_ready  = (state_q == IDLE);
    assign cpu_resp_valid = (state_q == RESP);
    assign cpu_resp_err   = (state_q == RESP) && err_q;
    assign cpu_rdata      = rdata_q;
    assign mem_store_req  = (state_q == WB);
    assign mem_load_req   = (state_q == FILL);

    // In WB the array still holds the victim, so its tag forms the address.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WB: begin
                mem_addr  = {arr_tag, req_idx_q, 2'b00};
                mem_wdata = arr_data;
            end
            FILL:    mem_addr = {req_tag_q, req_idx_q, 2'b00};
            default: ;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q,  hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        accept_aligned;

    always_comb begin
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        accept_aligned = (state_q == IDLE) && cpu_req_valid && !cpu_addr[0];
        if (accept_aligned && hit && (hit_cnt_q != 16'hFFFF))
            hit_cnt_d = hit_cnt_q + 16'd1;
        if (accept_aligned && !hit && (miss_cnt_q != 16'hFFFF))
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
module tb_dcache_mem_ctrl;
    import dcache_pkg::*;

    localparam int BOUND = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    instr_type_t cpu_req_type = READ;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_resp_valid;
    logic [15:0] cpu_rdata;
    logic        cpu_resp_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_store_req;
    logic        mem_store_done = 1'b0;
    logic        mem_load_req;
    logic        mem_load_done = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // Memory model state
    logic [31:0] ram [0:16383];
    int          mem_delay = 0;
    int          st_wait = 0;
    int          ld_wait = 0;
    int          store_cnt = 0;
    int          load_cnt = 0;
    int          load_hi_cycles = 0;
    logic [15:0] last_store_addr = '0;
    logic [31:0] last_store_data = '0;
    logic [15:0] last_load_addr = '0;

    dcache_mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_type   (cpu_req_type),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_rdata      (cpu_rdata),
        .cpu_resp_err   (cpu_resp_err),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_store_req  (mem_store_req),
        .mem_store_done (mem_store_done),
        .mem_load_req   (mem_load_req),
        .mem_load_done  (mem_load_done),
        .mem_rdata      (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Block RAM model: done rises on the (mem_delay+1)-th falling edge of a
    // held request and is sampled by the DUT on the following rising edge.
    always @(negedge clk) begin
        if (mem_store_req) begin
            if (st_wait == mem_delay) begin
                ram[mem_addr[15:2]] = mem_wdata;
                last_store_addr = mem_addr;
                last_store_data = mem_wdata;
                store_cnt++;
                mem_store_done = 1'b1;
            end else begin
                st_wait++;
                mem_store_done = 1'b0;
            end
        end else begin
            st_wait = 0;
            mem_store_done = 1'b0;
        end
        if (mem_load_req) begin
            load_hi_cycles++;
            if (ld_wait == mem_delay) begin
                mem_rdata = ram[mem_addr[15:2]];
                last_load_addr = mem_addr;
                load_cnt++;
                mem_load_done = 1'b1;
            end else begin
                ld_wait++;
                mem_load_done = 1'b0;
            end
        end else begin
            ld_wait = 0;
            mem_load_done = 1'b0;
        end
    end

    task automatic do_req(input logic [15:0] addr, input instr_type_t typ,
                          input logic [15:0] wd, output logic [15:0] rdata,
                          output logic err, output int lat, output logic pulse_ok);
        logic seen;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_addr      = addr;
        cpu_req_type  = typ;
        cpu_wdata     = wd;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        lat = 0;
        seen = 1'b0;
        rdata = 'x;
        err = 1'bx;
        while (!seen && lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (cpu_resp_valid) begin
                seen  = 1'b1;
                rdata = cpu_rdata;
                err   = cpu_resp_err;
            end
        end
        checks++;
        if (!seen) begin
            fails++;
            $display("FAIL resp_timeout addr=%h got=none required=resp within %0d cycles", addr, BOUND);
        end
        @(negedge clk);
        pulse_ok = !cpu_resp_valid && cpu_req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (cpu_req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", cpu_req_ready); end
        checks++; if (cpu_resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got=%b exp=0", cpu_resp_valid); end
        checks++; if (cpu_resp_err !== 1'b0) begin fails++; $display("FAIL rst_resp_err got=%b exp=0", cpu_resp_err); end
        checks++; if ({mem_store_req, mem_load_req} !== 2'b00) begin fails++; $display("FAIL rst_mem_reqs got=%b exp=00", {mem_store_req, mem_load_req}); end
        checks++; if (cpu_rdata !== 16'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0000", cpu_rdata); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    endtask

    task automatic test_cold_read();
        logic [15:0] rd; logic er; int lat; logic pok; int l0;
        l0 = load_cnt;
        do_req(16'h0004, READ, 16'h0, rd, er, lat, pok);
        checks++; if (rd !== 16'h1234) begin fails++; $display("FAIL cold_rdata got=%h exp=1234", rd); end
        checks++; if (lat !== 2) begin fails++; $display("FAIL cold_latency got=%0d exp=2", lat); end
        checks++; if (last_load_addr !== 16'h0004 || load_cnt !== l0 + 1) begin fails++; $display("FAIL cold_fill got=%h/%0d exp=0004/%0d", last_load_addr, load_cnt - l0, 1); end
        l0 = load_cnt;
        do_req(16'h0006, READ, 16'h0, rd, er, lat, pok);
        checks++; if (rd !== 16'hBEEF) begin fails++; $display("FAIL hit_rdata got=%h exp=BEEF", rd); end
        checks++; if (lat !== 1 || !pok) begin fails++; $display("FAIL hit_latency got=%0d/%b exp=1/1", lat, pok); end
        checks++; if (load_cnt !== l0) begin fails++; $display("FAIL hit_no_mem got=%0d exp=0 loads", load_cnt - l0); end
    endtask

    task automatic test_write_alloc();
        logic [15:0] rd; logic er; int lat; logic pok; int s0;
        do_req(16'h0008, WRITE, 16'hA5A5, rd, er, lat, pok);
        checks++; if (lat !== 2 || rd !== 16'h0 || last_load_addr !== 16'h0008) begin fails++; $display("FAIL wr_cold got=lat%0d/%h/%h exp=lat2/0000/0008", lat, rd, last_load_addr); end
        s0 = store_cnt;
        do_req(16'h0028, WRITE, 16'h5A5A, rd, er, lat, pok);
        checks++; if (store_cnt !== s0 + 1 || last_store_addr !== 16'h0008) begin fails++; $display("FAIL wb_addr got=%0d/%h exp=1/0008", store_cnt - s0, last_store_addr); end
        checks++; if (last_store_data !== 32'h1111_A5A5) begin fails++; $display("FAIL wb_data got=%h exp=1111a5a5", last_store_data); end
        checks++; if (last_load_addr !== 16'h0028 || lat !== 3) begin fails++; $display("FAIL wb_then_fill got=%h/lat%0d exp=0028/lat3", last_load_addr, lat); end
        do_req(16'h002A, READ, 16'h0, rd, er, lat, pok);
        checks++; if (rd !== 16'h3333 || lat !== 1) begin fails++; $display("FAIL evict_hi got=%h/lat%0d exp=3333/lat1", rd, lat); end
        do_req(16'h0028, READ, 16'h0, rd, er, lat, pok);
        checks++; if (rd !== 16'h5A5A || lat !== 1) begin fails++; $display("FAIL evict_merged got=%h/lat%0d exp=5a5a/lat1", rd, lat); end
    endtask

    task automatic test_misaligned();
        logic [15:0] rd; logic er; int lat; logic pok; int l0;
        l0 = load_cnt;
        do_req(16'h0003, READ, 16'h0, rd, er, lat, pok);
        checks++; if (er !== 1'b1 || rd !== 16'h0) begin fails++; $display("FAIL misal_resp got=err%b/%h exp=err1/0000", er, rd); end
        checks++; if (lat !== 1 || load_cnt !== l0 || !pok) begin fails++; $display("FAIL misal_nomem got=lat%0d/%0d/%b exp=lat1/0/1", lat, load_cnt - l0, pok); end
        do_req(16'h0000, READ, 16'h0, rd, er, lat, pok);
        checks++; if (lat !== 2 || rd !== 16'hCAFE || er !== 1'b0) begin fails++; $display("FAIL misal_unchanged got=lat%0d/%h/%b exp=lat2/cafe/0", lat, rd, er); end
    endtask

    task automatic test_mem_delay();
        logic [15:0] rd; logic er; int lat; logic pok; int h0;
        logic [15:0] addrs [3];
        logic [15:0] exps  [3];
        int          dlys  [3];
        addrs = '{16'h0010, 16'h0016, 16'h0018};
        exps  = '{16'h2020, 16'h3030, 16'h6060};
        dlys  = '{0, 1, 7};
        for (int i = 0; i < 3; i++) begin
            mem_delay = dlys[i];
            h0 = load_hi_cycles;
            do_req(addrs[i], READ, 16'h0, rd, er, lat, pok);
            checks++; if (rd !== exps[i]) begin fails++; $display("FAIL dly%0d_rdata got=%h exp=%h", dlys[i], rd, exps[i]); end
            checks++; if (load_hi_cycles - h0 !== dlys[i] + 1) begin fails++; $display("FAIL dly%0d_req_len got=%0d exp=%0d", dlys[i], load_hi_cycles - h0, dlys[i] + 1); end
            checks++; if (lat !== dlys[i] + 2 || !pok) begin fails++; $display("FAIL dly%0d_pulse got=lat%0d/%b exp=lat%0d/1", dlys[i], lat, pok, dlys[i] + 2); end
        end
        mem_delay = 0;
    endtask

    task automatic test_reset_mid_wb();
        logic [15:0] rd; logic er; int lat; logic pok; int l0;
        do_req(16'h000C, WRITE, 16'h9999, rd, er, lat, pok);
        mem_delay = 7;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_addr      = 16'h002C;
        cpu_req_type  = READ;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_store_req !== 1'b1 || mem_addr !== 16'h000C) begin fails++; $display("FAIL wb_started got=%b/%h exp=1/000c", mem_store_req, mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({mem_store_req, mem_load_req, cpu_req_ready} !== 3'b001) begin fails++; $display("FAIL rst_drop got=%b exp=001", {mem_store_req, mem_load_req, cpu_req_ready}); end
        @(negedge clk);
        rst = 1'b0;
        mem_delay = 0;
        l0 = load_cnt;
        do_req(16'h000C, READ, 16'h0, rd, er, lat, pok);
        checks++; if (lat !== 2 || load_cnt !== l0 + 1 || rd !== 16'h8888) begin fails++; $display("FAIL rst_invalidates got=lat%0d/%0d/%h exp=lat2/1/8888", lat, load_cnt - l0, rd); end
        checks++; if (ram[3] !== 32'h7777_8888) begin fails++; $display("FAIL rst_no_wb got=%h exp=77778888", ram[3]); end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        logic [15:0] rd; logic er; int lat; logic pok;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin fails++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
        do_req(16'h0004, READ, 16'h0, rd, er, lat, pok);
        do_req(16'h0006, READ, 16'h0, rd, er, lat, pok);
        do_req(16'h0004, WRITE, 16'h1, rd, er, lat, pok);
        do_req(16'h0008, READ, 16'h0, rd, er, lat, pok);
        do_req(16'h000A, READ, 16'h0, rd, er, lat, pok);
        do_req(16'h0001, READ, 16'h0, rd, er, lat, pok);
        checks++; if (hit_cnt !== 16'd3) begin fails++; $display("FAIL stats_hits got=%0d exp=3", hit_cnt); end
        checks++; if (miss_cnt !== 16'd2) begin fails++; $display("FAIL stats_misses got=%0d exp=2", miss_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[0]  = 32'h0000_CAFE;
        ram[1]  = 32'hBEEF_1234;
        ram[2]  = 32'h1111_2222;
        ram[3]  = 32'h7777_8888;
        ram[4]  = 32'h1010_2020;
        ram[5]  = 32'h3030_4040;
        ram[6]  = 32'h5050_6060;
        ram[10] = 32'h3333_4444;

        test_reset();
        test_cold_read();
        test_write_alloc();
        test_misaligned();
        test_mem_delay();
        test_reset_mid_wb();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
